// File: rtl/gcm_pkg.sv
// Shared definitions for the GCM result path: block/result widths, streamer
// state encoding and the words-per-result helper.
package gcm_pkg;

  localparam int unsigned GCM_BLK_W = 128;
  localparam int unsigned GCM_RES_W = 512;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Number of output words needed to carry one 512-bit result
  function automatic int unsigned nwords(input int unsigned out_w);
    return GCM_RES_W / out_w;
  endfunction

endpackage

// File: rtl/gcm_result_streamer.sv
// Captures the GCM core's 512-bit result (ct1, ct2, ct3, tag) on the rising
// edge of core_done and streams it MSB-first as OUT_W-bit words over
// valid/ready. Optional tag comparison is enabled by defining GCM_TAG_CHECK_EN.
module gcm_result_streamer
  import gcm_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_done,
  input  logic [GCM_BLK_W-1:0] ciphertext1,
  input  logic [GCM_BLK_W-1:0] ciphertext2,
  input  logic [GCM_BLK_W-1:0] ciphertext3,
  input  logic [GCM_BLK_W-1:0] tag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_W-1:0]     m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 overrun
`ifdef GCM_TAG_CHECK_EN
  ,
  input  logic [GCM_BLK_W-1:0] exp_tag,
  output logic                 auth_valid,
  output logic                 auth_ok
`endif
);

  localparam int unsigned NWORDS = nwords(OUT_W);
  localparam int unsigned CNT_W  = $clog2(NWORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  // Reject unsupported word widths at elaboration
  generate
    if (!(OUT_W == 32 || OUT_W == 64 || OUT_W == 128)) begin : g_bad_out_w
      $fatal(1, "gcm_result_streamer: OUT_W must be 32, 64 or 128");
    end
  endgenerate

  state_t                        state;
  logic                          done_q;
  logic [CNT_W-1:0]              cnt;
  logic [NWORDS-1:0][OUT_W-1:0]  res_buf;
  logic [NWORDS-1:0][OUT_W-1:0]  res_in;
  logic [CNT_W-1:0]              cnt_nxt;
  logic                          cap;

  // Word NWORDS-1 of the packed view is the MSB end (ciphertext1 top bits)
  assign res_in  = {ciphertext1, ciphertext2, ciphertext3, tag};
  assign cap     = core_done & ~done_q;
  assign cnt_nxt = CNT_W'(cnt + 1'b1);

  // Edge detect, capture buffer and stream FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      cnt        <= '0;
      res_buf    <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef GCM_TAG_CHECK_EN
      auth_valid <= 1'b0;
      auth_ok    <= 1'b0;
`endif
    end else begin
      done_q  <= core_done;
      overrun <= 1'b0;
`ifdef GCM_TAG_CHECK_EN
      auth_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cap) begin
            res_buf <= res_in;
            m_valid <= 1'b1;
            m_data  <= res_in[NWORDS-1];
            m_last  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= STREAM;
`ifdef GCM_TAG_CHECK_EN
            auth_valid <= 1'b1;
            auth_ok    <= (tag == exp_tag);
`endif
          end
        end
        STREAM: begin
          // A new result while the buffer is occupied (including the final
          // handshake cycle) is dropped and flagged.
          overrun <= cap;
          if (m_valid && m_ready) begin
            if (cnt == LAST_IDX) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              cnt    <= cnt_nxt;
              m_data <= res_buf[LAST_IDX - cnt_nxt];
              m_last <= (cnt_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_result_streamer.sv
// Directed bench for gcm_result_streamer: a table of stream scenarios on a
// 32-bit instance, plus a hand-written 128-bit sequence (with tag check when
// GCM_TAG_CHECK_EN is defined).
module tb_gcm_result_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic         core_done;
  logic [127:0] ct1, ct2, ct3, tg;
  logic         m_ready, m_ready128;

  logic         m_valid, m_last, busy, overrun;
  logic [31:0]  m_data;
  logic         m_valid128, m_last128, busy128, overrun128;
  logic [127:0] m_data128;
`ifdef GCM_TAG_CHECK_EN
  logic [127:0] exp_tag;
  logic         auth_valid, auth_ok, auth_valid32, auth_ok32;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gcm_result_streamer #(.OUT_W(32)) dut32 (
    .clk(clk), .rst(rst), .core_done(core_done),
    .ciphertext1(ct1), .ciphertext2(ct2), .ciphertext3(ct3), .tag(tg),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .overrun(overrun)
`ifdef GCM_TAG_CHECK_EN
    , .exp_tag(exp_tag), .auth_valid(auth_valid32), .auth_ok(auth_ok32)
`endif
  );

  gcm_result_streamer #(.OUT_W(128)) dut128 (
    .clk(clk), .rst(rst), .core_done(core_done),
    .ciphertext1(ct1), .ciphertext2(ct2), .ciphertext3(ct3), .tag(tg),
    .m_valid(m_valid128), .m_ready(m_ready128), .m_data(m_data128), .m_last(m_last128),
    .busy(busy128), .overrun(overrun128)
`ifdef GCM_TAG_CHECK_EN
    , .exp_tag(exp_tag), .auth_valid(auth_valid), .auth_ok(auth_ok)
`endif
  );

  typedef struct {
    logic [127:0] c1, c2, c3, t;
    logic [7:0]   rdy;      // m_ready pattern, bit [cycle % 8]
    int           hold;     // cycles core_done stays high
    int           ovr_at;   // word index at which a second done edge arrives
    int           rst_at;   // word index at which reset is asserted
  } case_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Run one capture + stream on the 32-bit instance and check every word
  task automatic run_case(input case_t c, input int id,
                          output logic [31:0] first_w, output logic [31:0] last_w);
    logic [511:0] res;
    int k, cyc, hold, inj_cyc;
    bit injected;
    string nm;
    nm = $sformatf("case%0d", id);
    res = {c.c1, c.c2, c.c3, c.t};
    first_w = '0;
    last_w  = '0;
    @(negedge clk);
    ct1 = c.c1; ct2 = c.c2; ct3 = c.c3; tg = c.t;
    core_done = 1'b1;
    m_ready = 1'b0;
    hold = c.hold;
    injected = 0;
    inj_cyc = -10;
    @(negedge clk);
    chk({nm, " first_valid"}, m_valid, 1'b1);
    k = 0;
    cyc = 0;
    while (k < 16 && cyc < 200) begin
      if (!injected) begin
        if (hold > 0) hold--;
        if (hold == 0) core_done = 1'b0;
      end else if (cyc == inj_cyc + 1) begin
        core_done = 1'b0;
        ct1 = c.c1; ct2 = c.c2; ct3 = c.c3; tg = c.t;
      end
      chk({nm, $sformatf(" valid w%0d", k)}, m_valid, 1'b1);
      chk({nm, $sformatf(" busy w%0d", k)}, busy, 1'b1);
      chk({nm, $sformatf(" overrun c%0d", cyc)}, overrun,
          (injected && cyc == inj_cyc + 1) ? 1'b1 : 1'b0);
      chk({nm, $sformatf(" data w%0d", k)}, m_data, res[511 - 32*k -: 32]);
      chk({nm, $sformatf(" last w%0d", k)}, m_last, (k == 15) ? 1'b1 : 1'b0);
      if (k == 0)  first_w = m_data;
      if (k == 15) last_w  = m_data;
      if (k == c.rst_at) begin
        rst = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        chk({nm, " rst valid"}, m_valid, 1'b0);
        chk({nm, " rst busy"}, busy, 1'b0);
        chk({nm, " rst last"}, m_last, 1'b0);
        chk({nm, " rst data"}, m_data, 32'h0);
        rst = 1'b0;
        core_done = 1'b0;
        return;
      end
      if (k == c.ovr_at && !injected) begin
        injected = 1;
        inj_cyc = cyc;
        core_done = 1'b1;
        ct1 = ~c.c1; ct2 = ~c.c2; ct3 = ~c.c3; tg = ~c.t;
      end
      m_ready = c.rdy[cyc % 8];
      if (m_ready) k++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) chk({nm, " timeout"}, 1'b1, 1'b0);
    m_ready = 1'b0;
    core_done = 1'b0;
    chk({nm, " end valid"}, m_valid, 1'b0);
    chk({nm, " end busy"}, busy, 1'b0);
    chk({nm, " end last"}, m_last, 1'b0);
    chk({nm, " end overrun"}, overrun, 1'b0);
  endtask

  localparam logic [127:0] D1_C1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] D1_C2 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] D1_C3 = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] D1_T  = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;

  initial begin
    case_t cases [6];
    logic [31:0] fw, lw;
    logic [127:0] w128 [4];

    cases[0] = '{D1_C1, D1_C2, D1_C3, D1_T, 8'hFF, 1, 99, 99};
    cases[1] = '{D1_C1, D1_C2, D1_C3, D1_T, 8'h99, 1, 99, 99};
    cases[2] = '{D1_C1, D1_C2, D1_C3, D1_T, 8'hFF, 5, 99, 99};
    cases[3] = '{D1_C1, D1_C2, D1_C3, D1_T, 8'hFF, 1, 4, 99};
    cases[4] = '{D1_C1, D1_C2, D1_C3, D1_T, 8'hFF, 1, 99, 7};
    cases[5] = '{128'hFFEEDDCCBBAA99887766554433221100,
                 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0,
                 128'h13579BDF2468ACE0FEDCBA9876543210,
                 128'h55AA55AA_00FF00FF_A5A5A5A5_C3C3C3C3, 8'h6D, 2, 99, 99};

    rst = 1'b1; core_done = 1'b0; m_ready = 1'b0; m_ready128 = 1'b0;
    ct1 = '0; ct2 = '0; ct3 = '0; tg = '0;
`ifdef GCM_TAG_CHECK_EN
    exp_tag = '0;
`endif
    repeat (2) @(negedge clk);
    chk("reset valid", m_valid, 1'b0);
    chk("reset data", m_data, 32'h0);
    chk("reset last", m_last, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_case(cases[i], i, fw, lw);
      if (i == 0) begin
        chk("case0 first word", fw, 32'h00010203);
        chk("case0 last word", lw, 32'h89ABCDEF);
      end
    end

    // 128-bit instance: four words, m_last on the fourth, tag check
    w128[0] = D1_C1; w128[1] = D1_C2; w128[2] = D1_C3; w128[3] = D1_T;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ct1 = D1_C1; ct2 = D1_C2; ct3 = D1_C3; tg = D1_T;
`ifdef GCM_TAG_CHECK_EN
    exp_tag = D1_T;
`endif
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("w128 first_valid", m_valid128, 1'b1);
`ifdef GCM_TAG_CHECK_EN
    chk("auth_valid match", auth_valid, 1'b1);
    chk("auth_ok match", auth_ok, 1'b1);
`endif
    m_ready128 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w128 data w%0d", k), m_data128, w128[k]);
      chk($sformatf("w128 last w%0d", k), m_last128, (k == 3) ? 1'b1 : 1'b0);
      chk($sformatf("w128 overrun w%0d", k), overrun128, (k == 2) ? 1'b1 : 1'b0);
`ifdef GCM_TAG_CHECK_EN
      if (k > 0) begin
        chk($sformatf("auth_valid w%0d", k), auth_valid, 1'b0);
        chk($sformatf("auth_ok hold w%0d", k), auth_ok, 1'b1);
      end
`endif
      core_done = (k == 1);
      @(negedge clk);
    end
    core_done = 1'b0;
    chk("w128 end valid", m_valid128, 1'b0);
    chk("w128 end busy", busy128, 1'b0);

`ifdef GCM_TAG_CHECK_EN
    exp_tag = D1_T ^ 128'h1;
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("auth_valid mismatch", auth_valid, 1'b1);
    chk("auth_ok mismatch", auth_ok, 1'b0);
    repeat (5) @(negedge clk);
    chk("auth drain busy", busy128, 1'b0);
`endif

    m_ready128 = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
